// File: rtl/rom_seq_reader.sv
// Sequencer for a small combinational ROM. It sweeps an inclusive, wrapping
// address window and streams each word out on valid/ready with a running sum and count.
module rom_seq_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        first_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     rom_rd_en,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum,
  output logic [ADDR_W:0]          count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

  state_t            state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] last_r;

  // Sweep FSM; every output is a register updated together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cur_r     <= {ADDR_W{1'b0}};
      last_r    <= {ADDR_W{1'b0}};
      rom_addr  <= {ADDR_W{1'b0}};
      rom_rd_en <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= {(DATA_W+ADDR_W){1'b0}};
      count     <= {(ADDR_W+1){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cur_r     <= first_addr;
            last_r    <= last_addr;
            sum       <= {(DATA_W+ADDR_W){1'b0}};
            count     <= {(ADDR_W+1){1'b0}};
            rom_addr  <= first_addr;
            rom_rd_en <= 1'b1;
            busy      <= 1'b1;
            state_r   <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          sum       <= sum + {{ADDR_W{1'b0}}, rom_data};
          count     <= count + COUNT_ONE;
          rom_addr  <= {ADDR_W{1'b0}};
          rom_rd_en <= 1'b0;
          state_r   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cur_r == last_r) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              // Address arithmetic wraps naturally at the ROM depth
              cur_r     <= cur_r + ADDR_ONE;
              rom_addr  <= cur_r + ADDR_ONE;
              rom_rd_en <= 1'b1;
              state_r   <= READ;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          rom_addr  <= {ADDR_W{1'b0}};
          rom_rd_en <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_seq_reader.sv
// Randomized bench for rom_seq_reader: an arithmetic window model predicts the
// word stream, sum, count, read-enable cycles and done pulse of each sweep.
module tb_rom_seq_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [ADDR_W-1:0]        first_addr = 4'd0;
  logic [ADDR_W-1:0]        last_addr = 4'd0;
  logic [ADDR_W-1:0]        rom_addr;
  logic                     rom_rd_en;
  logic [DATA_W-1:0]        rom_data;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     busy;
  logic                     done;
  logic [DATA_W+ADDR_W-1:0] sum;
  logic [ADDR_W:0]          count;

  int n_vec = 0;
  int n_err = 0;

  rom_seq_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .sum(sum), .count(count)
  );

  assign rom_data = 32'hA000_0000 | {28'd0, rom_addr};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input int a);
    return 32'hA000_0000 | 32'(a % DEPTH);
  endfunction

  // One sweep from a start pulse to the cycle after done, checked against the window model
  task automatic run_sweep(input int first, input int last, input int ready_pct,
                           input bit stall_second, input int restart_cyc, input string tag);
    int n;
    logic [35:0] exp_sum;
    int k, rd, dn, cyc, first_v, stall_ctr;
    bit fin, pend;
    logic [31:0] prev;
    n = ((last - first + DEPTH) % DEPTH) + 1;
    exp_sum = 36'd0;
    for (int i = 0; i < n; i++) exp_sum += {4'd0, rom_word(first + i)};
    k = 0; rd = 0; dn = 0; first_v = -1; stall_ctr = 0; fin = 1'b0; pend = 1'b0;
    prev = 32'd0;
    @(negedge clk);
    start = 1'b1;
    first_addr = 4'(first);
    last_addr = 4'(last);
    @(negedge clk);
    start = 1'b0;
    first_addr = 4'($urandom);
    last_addr = 4'($urandom);
    cyc = 1;
    while (cyc < 600 && !fin) begin
      if (rom_rd_en) begin
        check_eq({tag, "_addr"}, 64'(rom_addr), 64'((first + rd) % DEPTH));
        rd++;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && pend) check_eq({tag, "_stable"}, 64'(out_data), 64'(prev));
      if (out_valid) begin
        if (stall_second && k == 1 && stall_ctr < 5) begin
          out_ready = 1'b0;
          stall_ctr++;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_ready) begin
          check_eq({tag, "_word"}, 64'(out_data), 64'(rom_word(first + k)));
          k++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          prev = out_data;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      if (done) begin
        dn++;
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check_eq({tag, "_count"}, 64'(count), 64'(n));
      end else if (dn > 0) begin
        fin = 1'b1;
      end
      if (cyc == restart_cyc) begin
        start = 1'b1;
        first_addr = 4'($urandom);
        last_addr = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check_eq({tag, "_finished"}, 64'(fin), 64'd1);
    check_eq({tag, "_done_cycles"}, 64'(dn), 64'd1);
    check_eq({tag, "_rd_cycles"}, 64'(rd), 64'(n));
    check_eq({tag, "_words"}, 64'(k), 64'(n));
    check_eq({tag, "_latency"}, 64'(first_v), 64'd2);
    check_eq({tag, "_sum_hold"}, 64'(sum), 64'(exp_sum));
    check_eq({tag, "_count_hold"}, 64'(count), 64'(n));
  endtask

  initial begin
    int f, l;
    #3;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_rd_en", 64'(rom_rd_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(2, 5, 100, 1'b0, -1, "t1");
    check_eq("t1_sum_const", 64'(sum), 64'h2_8000_000E);
    run_sweep(14, 1, 100, 1'b0, -1, "t2_wrap");
    run_sweep(3, 3, 100, 1'b0, -1, "t3_single");
    run_sweep(0, 15, 100, 1'b0, -1, "t3_full");
    check_eq("t3_full_sum_const", 64'(sum), 64'hA_0000_0078);
    run_sweep(9, 8, 100, 1'b0, -1, "full_wrap");
    run_sweep(2, 5, 100, 1'b1, -1, "t4_stall");
    run_sweep(4, 9, 100, 1'b0, 3, "t5_restart");

    // Asynchronous reset while a word is waiting in HOLD
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; first_addr = 4'd2; last_addr = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check_eq("t6_in_hold", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", 64'(out_valid), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_rd_en", 64'(rom_rd_en), 64'd0);
    check_eq("t6_sum", 64'(sum), 64'd0);
    check_eq("t6_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t6_no_done", 64'(done), 64'd0);
      check_eq("t6_idle", 64'(busy), 64'd0);
    end
    run_sweep(2, 5, 100, 1'b0, -1, "t6_after");

    for (int s = 0; s < 20; s++) begin
      f = int'($urandom_range(DEPTH - 1));
      l = int'($urandom_range(DEPTH - 1));
      run_sweep(f, l, 50, s[0], (s % 3 == 0) ? 4 : -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
